// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer driving one shared 1-bit adder_subtractor cell.
// Operands are processed LSB first, one bit per clock, with carry/borrow and signed overflow.
module serial_addsub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_mode,
  output logic             cell_cin,
  input  logic             cell_result,
  input  logic             cell_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg;
  logic             mode_reg, carry_reg, cout_reg, ovf_reg;
  logic [CW-1:0]    cnt_reg;
  logic             last_bit;
  logic             accept;

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  assign accept   = (state_reg == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Cell inputs are only driven in RUN so the shared cell sees zeros otherwise.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    cell_a     = 1'b0;
    cell_b     = 1'b0;
    cell_mode  = 1'b0;
    cell_cin   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        cell_a    = a_sh_reg[0];
        cell_b    = b_sh_reg[0];
        cell_mode = mode_reg;
        cell_cin  = carry_reg;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      mode_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b;
      mode_reg  <= mode;
      carry_reg <= mode;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      res_sh_reg <= {cell_result, res_sh_reg[WIDTH-1:1]};
      a_sh_reg   <= a_sh_reg >> 1;
      b_sh_reg   <= b_sh_reg >> 1;
      carry_reg  <= cell_cout;
      cnt_reg    <= cnt_reg + CW'(1);
      // carry_reg still holds the carry into the MSB on this edge.
      if (last_bit) begin
        ovf_reg  <= carry_reg ^ cell_cout;
        cout_reg <= cell_cout;
      end
    end
  end

  assign result   = res_sh_reg;
  assign cout     = cout_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl with a behavioural 1-bit cell and a result scoreboard.
module tb_serial_addsub_ctrl;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [W-1:0] a, b;
  logic         busy, done, cout, overflow;
  logic [W-1:0] result;
  logic         cell_a, cell_b, cell_mode, cell_cin, cell_result, cell_cout;
  logic         cell_bx;

  int           n_vectors = 0;
  int           n_miscompares = 0;
  int           cycle = 0;
  int           c0 = 0;
  bit           inflight = 1'b0;
  logic [W-1:0] cur_a, cur_b, last_res;
  logic         cur_mode;
  exp_t         sb[$];

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow),
    .cell_a(cell_a), .cell_b(cell_b), .cell_mode(cell_mode), .cell_cin(cell_cin),
    .cell_result(cell_result), .cell_cout(cell_cout)
  );

  // Reference 1-bit adder_subtractor cell.
  assign cell_bx     = cell_b ^ cell_mode;
  assign cell_result = cell_a ^ cell_bx ^ cell_cin;
  assign cell_cout   = (cell_a & cell_bx) | (cell_a & cell_cin) | (cell_bx & cell_cin);

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xm);
    logic [W-1:0] bx;
    logic [W:0]   s;
    exp_t         e;
    bx     = xb ^ {W{xm}};
    s      = {1'b0, xa} + {1'b0, bx} + {{W{1'b0}}, xm};
    e.res  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (xa[W-1] == bx[W-1]) && (s[W-1] != xa[W-1]);
    return e;
  endfunction

  // Caller positions us between edges with the DUT idle.
  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xm);
    a     = xa;
    b     = xb;
    mode  = xm;
    start = 1'b1;
    sb.push_back(model(xa, xb, xm));
    $display("op a=%04h b=%04h mode=%0d", xa, xb, xm);
    @(posedge clk);
    #1;
    c0       = cycle;
    cur_a    = xa;
    cur_b    = xb;
    cur_mode = xm;
    inflight = 1'b1;
    start    = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    mode     = 1'($urandom);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (!inflight) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      inflight = 1'b0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_cout"}, cout, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_cells"}, {cell_a, cell_b, cell_mode, cell_cin}, 0);
  endtask

  // Per-cycle monitor: busy/done timing, cell drive, and scoreboard pop on done.
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (rst_n === 1'b1) begin
      if (inflight) begin
        d = cycle - c0;
        if (d < W) begin
          check("busy_run", busy, 1);
          check("done_early", done, 0);
          check("cell_a", cell_a, cur_a[d]);
          check("cell_b", cell_b, cur_b[d]);
          check("cell_mode", cell_mode, cur_mode);
          if (d == 0) check("cell_cin0", cell_cin, cur_mode);
        end else begin
          check("done_latency", done, 1);
          check("busy_done", busy, 0);
          if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("cout", cout, e.cout);
            check("overflow", overflow, e.ovf);
            last_res = e.res;
            $display("done result=%04h cout=%0d ovf=%0d (exp %04h %0d %0d)",
                     result, cout, overflow, e.res, e.cout, e.ovf);
          end
          inflight = 1'b0;
        end
      end else if (done) begin
        check("spurious_done", done, 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check_zero_outputs("idle");

    // Basic add, carry-out, signed overflow, subtract with borrow and overflow.
    @(negedge clk); #1; start_op(16'h1234, 16'h0FF0, 1'b0); wait_done();
    @(negedge clk); #1; start_op(16'hFFFF, 16'h0001, 1'b0); wait_done();
    @(negedge clk); #1; start_op(16'h7FFF, 16'h0001, 1'b0); wait_done();
    @(negedge clk); #1; start_op(16'h0005, 16'h0007, 1'b1); wait_done();
    @(negedge clk); #1; start_op(16'h8000, 16'h0001, 1'b1); wait_done();

    // start during RUN must be ignored.
    @(negedge clk); #1; start_op(16'h0001, 16'h0002, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    a = 16'hAAAA; b = 16'h5555; mode = 1'b1; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done();

    // Back-to-back: start in the first IDLE cycle after done; result held meanwhile.
    @(negedge clk); #1; start_op(16'h4321, 16'h1111, 1'b1); wait_done();
    @(negedge clk); #1;
    check("hold_idle", result, last_res);
    start_op(16'hC000, 16'h8000, 1'b0); wait_done();
    repeat (3) @(negedge clk);
    #1;
    check("hold_later", result, last_res);
    check("busy_idle", busy, 0);

    // A few random operations.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      start_op(W'($urandom), W'($urandom), 1'($urandom));
      wait_done();
    end

    // Asynchronous reset in the middle of bit 8.
    @(negedge clk); #1; start_op(16'h1234, 16'h4321, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    rst_n    = 1'b0;
    inflight = 1'b0;
    sb.delete();
    #1;
    check_zero_outputs("midrun_rst");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check_zero_outputs("post_rst");
    start_op(16'h0010, 16'h0001, 1'b1); wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
